// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_pkg                                                         |
// | Brief   : Shared UART constants and receiver FSM state encoding            |
// |           (used by uart_rx_byte now, uart_tx later).                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package uart_pkg;

  // Payload width of one serial character.
  localparam int DATA_W = 8;

  // 12 MHz system clock / 115200 baud.
  localparam int CLKS_PER_BIT_DEF = 104;

  // Receiver states; PARITY is only visited when parity checking is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_sync                                                     |
// | Brief   : Two-flop synchronizer for the raw rx pin plus falling-edge       |
// |           detect on the synchronized line. Resets to idle-high so no       |
// |           false start is seen out of reset.                                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic prev;

  // Metastability chain plus one delayed copy of the synchronized line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      prev <= rx_s;
    end
  end

  // Start condition is a 1->0 transition only, so a line stuck low never retriggers.
  assign fall = prev & ~rx_s;

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_rx_byte                                                     |
// | Brief   : 8-bit LSB-first serial receiver, 1 stop bit, idle-high line.     |
// |           Emits byte + one-cycle valid strobe, framing-error strobe and,   |
// |           when built with UART_RX_PARITY_EN, a parity-error strobe.        |
// |           Without UART_RX_PARITY_EN the receiver is 8N1 and parity_err = 0.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  // Elaboration-time guard on the configuration.
  if (CLKS_PER_BIT < 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_byte: CLKS_PER_BIT must be >= 8 and PARITY_ODD must be 0 or 1");
  end

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  rx_state_t         state,      state_n;
  logic [CW-1:0]     clk_cnt,    clk_cnt_n;
  logic [2:0]        bit_cnt,    bit_cnt_n;
  logic [DATA_W-1:0] shift,      shift_n;
  logic [DATA_W-1:0] data_n;
  logic              data_valid_n;
  logic              frame_err_n;
  logic              busy_n;
`ifdef UART_RX_PARITY_EN
  logic              par_bit,    par_bit_n;
  logic              parity_err_n;
`endif

  // State, counters, shift register and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      clk_cnt    <= clk_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      data       <= data_n;
      data_valid <= data_valid_n;
      frame_err  <= frame_err_n;
      busy       <= busy_n;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_n;
      parity_err <= parity_err_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Next-state logic: bit timing, sampling and end-of-frame strobes.
  always_comb begin
    state_n      = state;
    clk_cnt_n    = clk_cnt;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    data_n       = data;
    data_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    busy_n       = busy;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit;
    parity_err_n = 1'b0;
`endif

    case (state)
      ST_IDLE: begin
        if (fall) begin
          clk_cnt_n = '0;
          busy_n    = 1'b1;
          state_n   = ST_START;
        end
      end

      // Re-check the line at mid start bit; a high here was a glitch.
      ST_START: begin
        if (clk_cnt == HALF_M1) begin
          clk_cnt_n = '0;
          if (!rx_s) begin
            bit_cnt_n = '0;
            state_n   = ST_DATA;
          end else begin
            busy_n    = 1'b0;
            state_n   = ST_IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end

      // One full bit period after mid start lands mid data bit.
      ST_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          shift_n   = {rx_s, shift[DATA_W-1:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n   = ST_PARITY;
`else
            state_n   = ST_STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n = '0;
          par_bit_n = rx_s;
          state_n   = ST_STOP;
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end
`endif

      // Mid stop bit: commit or flag, and go idle at once to leave margin
      // for a following start bit.
      ST_STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_cnt_n   = '0;
          busy_n      = 1'b0;
          state_n     = ST_IDLE;
          frame_err_n = ~rx_s;
`ifdef UART_RX_PARITY_EN
          parity_err_n = (par_bit != ((^shift) ^ 1'(PARITY_ODD)));
          if (rx_s && !parity_err_n) begin
            data_n       = shift;
            data_valid_n = 1'b1;
          end
`else
          if (rx_s) begin
            data_n       = shift;
            data_valid_n = 1'b1;
          end
`endif
        end else begin
          clk_cnt_n = clk_cnt + CW'(1);
        end
      end

      default: begin
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
`timescale 1ns/100ps
// +----------------------------------------------------------------------------+
// | Module  : tb_uart_rx_byte                                                  |
// | Brief   : Self-checking bench for uart_rx_byte at CLKS_PER_BIT = 16.       |
// |           Covers the parity variant when UART_RX_PARITY_EN is defined.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_rx_byte;

  localparam int C       = 16;
  localparam int CLK_NS  = 10;
  localparam int BIT_NS  = C * CLK_NS;
`ifdef UART_RX_PARITY_EN
  localparam int LAT     = 3 + C / 2 + 9 * C + C;
`else
  localparam int LAT     = 3 + C / 2 + 9 * C;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_byte #(.CLKS_PER_BIT(C), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  typedef struct {
    logic       dv;
    logic       fe;
    logic       pe;
    logic [7:0] d;
    realtime    t_fall;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       par;
    int         bit_ns;
    logic       exp_dv;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ^b;
  endfunction

  // Scoreboard consumer: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (data_valid || frame_err || parity_err)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: dv=%b fe=%b pe=%b data=%h required no strobe at %0t",
                 data_valid, frame_err, parity_err, data, $time);
      end else begin
        exp_t e;
        real  lat;
        e = sb.pop_front();
        check("strobe_data_valid", 32'(data_valid), 32'(e.dv));
        check("strobe_frame_err",  32'(frame_err),  32'(e.fe));
        check("strobe_parity_err", 32'(parity_err), 32'(e.pe));
        check("strobe_data",       32'(data),       32'(e.d));
        lat = ($realtime - (CLK_NS / 2) - e.t_fall) / CLK_NS;
        n_cmp++;
        if (lat < LAT - 1.5 || lat > LAT + 1.5) begin
          n_err++;
          $display("FAIL strobe_latency: actual=%0.1f cycles required=%0d +/-1", lat, LAT);
        end
      end
    end
  end

  // Drive one frame starting from the pin falling edge; records the expectation.
  task automatic run_frame(input logic [7:0] b, input logic stop, input logic par,
                           input int bit_ns, input logic dv, input logic fe,
                           input logic pe, input bit align, input int extra_low_ns);
    exp_t e;
    if (align) begin
      @(posedge clk);
      #1;
    end
    if (dv || fe || pe) begin
      e.dv = dv; e.fe = fe; e.pe = pe;
      e.d = dv ? b : last_good;
      e.t_fall = $realtime;
      sb.push_back(e);
      if (dv) last_good = b;
    end
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    #(bit_ns);
`else
    if (par) ; // unused in 8N1 builds
`endif
    rx = stop;
    #(bit_ns);
    if (!stop) #(extra_low_ns);
    rx = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h4F, 1'b1, 1'b1, 160, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h4F, 1'b1, 1'b0, 160, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h4F, 1'b1, 1'b1, 155, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h4F, 1'b1, 1'b1, 165, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h55, 1'b1, 1'b0, 160, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h55, 1'b1, 1'b1, 160, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h4F, 1'b0, 1'b0, 160, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 160, 1'b1, 1'b0, 1'b0});
`else
    vecs.push_back('{8'h4F, 1'b1, 1'b0, 160, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h46, 1'b1, 1'b0, 160, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 160, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 160, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h4F, 1'b1, 1'b0, 155, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h4F, 1'b1, 1'b0, 165, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h81, 1'b0, 1'b0, 160, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 160, 1'b1, 1'b0, 1'b0});
`endif

    // Reset state.
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(3);
    @(negedge clk);
    check("reset_data",       32'(data),       32'h00);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_frame_err",  32'(frame_err),  32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    check("reset_busy",       32'(busy),       32'd0);
    rst_n = 1'b1;
    idle(5);

    // Table-driven frames, each followed by an idle gap.
    foreach (vecs[k]) begin
      run_frame(vecs[k].b, vecs[k].stop, vecs[k].par, vecs[k].bit_ns,
                vecs[k].exp_dv, vecs[k].exp_fe, vecs[k].exp_pe, 1'b1, 0);
      wait_drain("table_drain", 4 * C);
      idle(2);
      @(negedge clk);
      check("table_busy_idle", 32'(busy), 32'd0);
      idle(2 * C);
    end

    // Back-to-back frames, one stop bit between them.
    run_frame(8'h4F, 1'b1, good_par(8'h4F), BIT_NS, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    run_frame(8'h46, 1'b1, good_par(8'h46), BIT_NS, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    wait_drain("b2b_drain", 4 * C);
    idle(2 * C);

    // Short low glitch: must be rejected without a strobe.
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("glitch_busy_set", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (busy == 1'b0) break;
      @(posedge clk);
      #1;
    end
    check("glitch_busy_clear", 32'(busy), 32'd0);
    idle(3 * C);

    // Framing error with line held low, then a clean frame.
    run_frame(8'h55, 1'b0, good_par(8'h55), BIT_NS, 1'b0, 1'b1, 1'b0, 1'b1, 40 * CLK_NS);
    wait_drain("frame_err_drain", 4 * C);
    check("frame_err_data_kept", 32'(data), 32'(last_good));
    idle(3 * C);
    run_frame(8'h46, 1'b1, good_par(8'h46), BIT_NS, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    wait_drain("after_fe_drain", 4 * C);
    idle(2 * C);

    // Mid-frame reset after four data bits of 8'hA5.
    @(posedge clk);
    #1;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0 || i == 2) ? 1'b1 : 1'b0;
      #(BIT_NS);
    end
    check("midreset_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_data",       32'(data),       32'h00);
    check("midreset_data_valid", 32'(data_valid), 32'd0);
    check("midreset_frame_err",  32'(frame_err),  32'd0);
    check("midreset_parity_err", 32'(parity_err), 32'd0);
    check("midreset_busy",       32'(busy),       32'd0);
    rx = 1'b1;
    last_good = 8'h00;
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2 * C);
    run_frame(8'hA5, 1'b1, good_par(8'hA5), BIT_NS, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    wait_drain("after_reset_drain", 4 * C);
    idle(3 * C);
    check("final_data", 32'(data), 32'hA5);
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
